// File: rtl/morse_decoder.sv
// Serial Morse digit receiver: times marks/spaces on the synchronised line, decodes
// digit characters 0-9 and emits the word as packed BCD when the word gap ends it.
module morse_decoder #(
    parameter int UNIT_CYCLES = 4800000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            serial_i,
    output logic [4*NUM_DIGITS-1:0]         value_o,
    output logic [$clog2(NUM_DIGITS+1)-1:0] digits_o,
    output logic                            valid_o,
    output logic                            overflow_o,
    output logic                            error_o,
    output logic                            busy_o
);
    localparam int CW = $clog2(8*UNIT_CYCLES+1);
    localparam int DW = $clog2(NUM_DIGITS+1);
    localparam int AW = 4*NUM_DIGITS;

    localparam logic [CW-1:0] T_SAT  = CW'(8*UNIT_CYCLES);
    localparam logic [CW-1:0] T_CHAR = CW'(2*UNIT_CYCLES);
    localparam logic [CW-1:0] T_WORD = CW'(5*UNIT_CYCLES);
    localparam logic [DW-1:0] D_MAX  = DW'(NUM_DIGITS);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, ERROR} state_t;

    state_t          state_q, state_d;
    logic [2:0]      sync_pipe;
    logic            line, line_prev, rise, fall;
    logic [CW-1:0]   run_q, len, space_len;
    logic [4:0]      sym_q, sym_d;
    logic [2:0]      scnt_q, scnt_d;
    logic [AW-1:0]   acc_q, acc_d, value_d;
    logic [DW-1:0]   dcnt_q, dcnt_d, digits_d;
    logic            ovf_q, ovf_d, ovfo_d, valid_d, error_d, goto_err;
    logic            dig_ok;
    logic [3:0]      dig;

    // Returns {ok, digit}; first symbol is in bit 4, dash = 1.
    function automatic logic [4:0] decode(input logic [4:0] p);
        case (p)
            5'b01111: return {1'b1, 4'd1};
            5'b00111: return {1'b1, 4'd2};
            5'b00011: return {1'b1, 4'd3};
            5'b00001: return {1'b1, 4'd4};
            5'b00000: return {1'b1, 4'd5};
            5'b10000: return {1'b1, 4'd6};
            5'b11000: return {1'b1, 4'd7};
            5'b11100: return {1'b1, 4'd8};
            5'b11110: return {1'b1, 4'd9};
            5'b11111: return {1'b1, 4'd0};
            default:  return 5'b0;
        endcase
    endfunction

    assign line      = sync_pipe[1];
    assign line_prev = sync_pipe[2];
    assign rise      = line & ~line_prev;
    assign fall      = ~line & line_prev;
    assign busy_o    = (state_q != IDLE);
    assign {dig_ok, dig} = decode(sym_q);

    // len: cycles at the current level including this one
    always_comb begin
        if (rise || fall)        len = CW'(1);
        else if (run_q == T_SAT) len = T_SAT;
        else                     len = run_q + CW'(1);
    end

    // On a rising edge the space just finished is run_q long
    assign space_len = line ? run_q : len;

    always_comb begin
        state_d  = state_q;
        sym_d    = sym_q;
        scnt_d   = scnt_q;
        acc_d    = acc_q;
        dcnt_d   = dcnt_q;
        ovf_d    = ovf_q;
        value_d  = value_o;
        digits_d = digits_o;
        ovfo_d   = overflow_o;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        goto_err = 1'b0;
        unique case (state_q)
            IDLE: if (rise) state_d = MARK;
            MARK: begin
                if (line && len > T_WORD) begin
                    goto_err = 1'b1;
                end else if (fall) begin
                    if (scnt_q == 3'd5) begin
                        goto_err = 1'b1;
                    end else begin
                        sym_d   = {sym_q[3:0], run_q >= T_CHAR};
                        scnt_d  = scnt_q + 3'd1;
                        state_d = SPACE;
                    end
                end
            end
            SPACE: begin
                if (scnt_q != 3'd0 && space_len >= T_CHAR) begin
                    if (scnt_q != 3'd5 || !dig_ok) begin
                        goto_err = 1'b1;
                    end else begin
                        acc_d  = (acc_q << 4) | AW'(dig);
                        sym_d  = '0;
                        scnt_d = '0;
                        if (dcnt_q == D_MAX) ovf_d = 1'b1;
                        else                 dcnt_d = dcnt_q + DW'(1);
                        if (rise) state_d = MARK;
                    end
                end else if (rise) begin
                    state_d = MARK;
                end else if (!line && len >= T_WORD) begin
                    state_d = IDLE;
                    if (dcnt_q != '0) begin
                        value_d  = acc_q;
                        digits_d = dcnt_q;
                        ovfo_d   = ovf_q;
                        valid_d  = 1'b1;
                    end
                    acc_d  = '0;
                    dcnt_d = '0;
                    ovf_d  = 1'b0;
                end
            end
            ERROR: if (!line && len >= T_WORD) state_d = IDLE;
        endcase
        if (goto_err) begin
            state_d = ERROR;
            error_d = 1'b1;
            sym_d   = '0;
            scnt_d  = '0;
            acc_d   = '0;
            dcnt_d  = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sync_pipe  <= '0;
            run_q      <= '0;
            sym_q      <= '0;
            scnt_q     <= '0;
            acc_q      <= '0;
            dcnt_q     <= '0;
            ovf_q      <= 1'b0;
            value_o    <= '0;
            digits_o   <= '0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_pipe  <= {sync_pipe[1:0], serial_i};
            run_q      <= len;
            sym_q      <= sym_d;
            scnt_q     <= scnt_d;
            acc_q      <= acc_d;
            dcnt_q     <= dcnt_d;
            ovf_q      <= ovf_d;
            value_o    <= value_d;
            digits_o   <= digits_d;
            overflow_o <= ovfo_d;
            valid_o    <= valid_d;
            error_o    <= error_d;
        end
    end
endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: line described as mark/space segments, expected words and
// errors derived from the segment lengths and compared against observed output pulses.
module tb_morse_decoder;
    localparam int U = 4;
    localparam int N = 8;

    logic         clk = 1'b0, rst = 1'b1, serial = 1'b0;
    logic [31:0]  value;
    logic [3:0]   digits;
    logic         valid, ovf, err, busy;

    morse_decoder #(.UNIT_CYCLES(U), .NUM_DIGITS(N)) dut (
        .clk_i(clk), .rst_i(rst), .serial_i(serial), .value_o(value),
        .digits_o(digits), .valid_o(valid), .overflow_o(ovf), .error_o(err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {bit is_err; logic [31:0] val; logic [3:0] cnt; bit ovf;} ev_t;
    typedef struct {bit lvl; int dur;} seg_t;

    ev_t  dut_q[$], exp_q[$];
    seg_t segs[$];
    int   wd[$];
    int   n_chk = 0, n_pass = 0, both = 0;
    bit   rnd_tim = 1'b0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) if (!rst) begin
        if (valid && err) both++;
        if (err) dut_q.push_back(ev_t'{1'b1, 32'h0, 4'h0, 1'b0});
        if (valid) dut_q.push_back(ev_t'{1'b0, value, digits, ovf});
    end

    function automatic int pick(int lo, int hi, int fixed);
        return rnd_tim ? int'($urandom_range(hi, lo)) : fixed;
    endfunction

    task automatic add(bit l, int d);
        seg_t s;
        s.lvl = l; s.dur = d;
        segs.push_back(s);
    endtask

    // n symbols, p[n-1] sent first, 1 = dash
    task automatic add_char(logic [5:0] p, int n);
        for (int i = n - 1; i >= 0; i--) begin
            add(1'b1, p[i] ? pick(2*U, 5*U, 3*U) : pick(1, 2*U-1, U));
            if (i > 0) add(1'b0, pick(1, 2*U-1, U));
        end
    endtask

    function automatic logic [5:0] enc(int d);
        logic [5:0] p;
        int k;
        bit dots_first;
        p = '0;
        dots_first = (d >= 1 && d <= 5);
        k = dots_first ? d : (d == 0 ? 5 : d - 5);
        for (int i = 0; i < 5; i++) p[4-i] = dots_first ? (i >= k) : (i < k);
        return p;
    endfunction

    task automatic add_word_q();
        foreach (wd[i]) begin
            add_char(enc(wd[i]), 5);
            add(1'b0, (i == wd.size() - 1) ? pick(5*U, 30, 7*U) : pick(2*U, 5*U-1, 3*U));
        end
        wd.delete();
    endtask

    task automatic add_word(string s);
        for (int i = 0; i < s.len(); i++) wd.push_back(int'(s[i]) - 48);
        add_word_q();
    endtask

    task automatic push_err();
        ev_t e;
        e.is_err = 1'b1; e.val = '0; e.cnt = '0; e.ovf = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_word(int dig[$]);
        ev_t e;
        int n;
        n = dig.size();
        e.is_err = 1'b0; e.val = '0;
        for (int i = (n > N ? n - N : 0); i < n; i++) e.val = (e.val << 4) | 32'(dig[i]);
        e.cnt = 4'(n > N ? N : n);
        e.ovf = (n > N);
        exp_q.push_back(e);
    endtask

    // Reference: walks the segments with the timing and character rules
    task automatic model();
        int mode;  // 0 idle, 1 in word, 2 error wait
        int d, k, v;
        bit ok;
        bit sym[$];
        int dig[$];
        mode = 0;
        foreach (segs[s]) begin
            d = segs[s].dur;
            if (segs[s].lvl) begin
                if (mode == 0) mode = 1;
                if (mode == 1) begin
                    if (d > 5*U || sym.size() == 5) begin
                        push_err(); mode = 2; sym.delete(); dig.delete();
                    end else sym.push_back(d >= 2*U);
                end
            end else if (mode == 2) begin
                if (d >= 5*U) mode = 0;
            end else if (mode == 1 && d >= 2*U) begin
                ok = (sym.size() == 5);
                k = 1; v = 0;
                if (ok) begin
                    while (k < 5 && sym[k] == sym[0]) k++;
                    for (int i = k; i < 5; i++) if (sym[i] == sym[0]) ok = 0;
                    v = sym[0] ? (k + 5) % 10 : k;
                end
                sym.delete();
                if (!ok) begin
                    push_err(); dig.delete();
                    mode = (d >= 5*U) ? 0 : 2;
                end else begin
                    dig.push_back(v);
                    if (d >= 5*U) begin push_word(dig); dig.delete(); mode = 0; end
                end
            end
        end
    endtask

    task automatic run(string tag);
        int last;
        last = segs.size() - 1;
        if (segs[last].lvl == 1'b1) add(1'b0, 30);
        else if (segs[last].dur < 30) segs[last].dur = 30;
        exp_q.delete();
        model();
        foreach (segs[i]) begin
            serial = segs[i].lvl;
            repeat (segs[i].dur) @(negedge clk);
        end
        serial = 1'b0;
        chk({tag, ".nev"}, dut_q.size(), exp_q.size());
        for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
            chk({tag, ".kind"}, dut_q[i].is_err, exp_q[i].is_err);
            chk({tag, ".val"}, dut_q[i].val, exp_q[i].val);
            chk({tag, ".cnt"}, dut_q[i].cnt, exp_q[i].cnt);
            chk({tag, ".ovf"}, dut_q[i].ovf, exp_q[i].ovf);
        end
        chk({tag, ".busy"}, busy, 1'b0);
        dut_q.delete();
        segs.delete();
    endtask

    initial begin
        int k;
        int nw, nd, r;
        repeat (3) @(negedge clk);
        chk("rst.val", value, 0);
        chk("rst.dig", digits, 0);
        chk("rst.flags", {valid, ovf, err, busy}, 4'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        add_word("1");
        run("one");
        chk("one.value", value, 32'h00000001);
        chk("one.digits", digits, 1);
        chk("one.ovf", ovf, 0);

        add_word("205");
        run("w205");
        chk("w205.value", value, 32'h00000205);
        chk("w205.digits", digits, 3);

        add_word("123456789");
        run("nine");
        chk("nine.value", value, 32'h23456789);
        chk("nine.digits", digits, 8);
        chk("nine.ovf", ovf, 1);

        add_char(6'b001010, 5);
        add(1'b0, 5*U);
        add_word("7");
        run("bad7");
        chk("bad7.value", value, 32'h00000007);
        chk("bad7.digits", digits, 1);

        // over-long mark: error 5U+1 cycles into the mark plus 2 sync cycles
        serial = 1'b1;
        k = 0;
        for (int i = 1; i <= 30 && k == 0; i++) begin
            @(negedge clk);
            if (err) k = i;
        end
        chk("long.lat", k, 5*U + 3);
        @(negedge clk);
        chk("long.pulse", err, 0);
        serial = 1'b0;
        repeat (5*U + 1) @(negedge clk);
        chk("long.busy_hi", busy, 1);
        @(negedge clk);
        chk("long.busy_lo", busy, 0);
        chk("long.nev", dut_q.size(), 1);
        if (dut_q.size() > 0) chk("long.kind", dut_q[0].is_err, 1);
        chk("long.hold", value, 32'h00000007);
        dut_q.delete();

        // reset after two dashes of a character
        serial = 1'b1; repeat (3*U) @(negedge clk);
        serial = 1'b0; repeat (U) @(negedge clk);
        serial = 1'b1; repeat (3*U) @(negedge clk);
        serial = 1'b0; repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid.val", value, 0);
        chk("mid.dig", digits, 0);
        chk("mid.flags", {valid, ovf, err, busy}, 4'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        dut_q.delete();
        add_word("9");
        run("nine_after_rst");
        chk("rst9.value", value, 32'h00000009);

        rnd_tim = 1'b1;
        for (int sc = 0; sc < 10; sc++) begin
            nw = $urandom_range(2, 1);
            for (int w = 0; w < nw; w++) begin
                nd = $urandom_range(10, 1);
                for (int c = 0; c < nd; c++) begin
                    r = $urandom_range(99, 0);
                    if (r < 8) add_char(6'($urandom), $urandom_range(6, 1));
                    else if (r < 12) add(1'b1, $urandom_range(6*U + 2, 5*U + 1));
                    else add_char(enc($urandom_range(9, 0)), 5);
                    add(1'b0, (c == nd - 1) ? pick(5*U, 30, 7*U) : pick(2*U, 5*U-1, 3*U));
                end
            end
            run("rnd");
        end

        chk("err_and_valid", both, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
- Receive-side counterpart of the on-chip Morse transmitter: samples a serial Morse line (mark = high, space = low) and recovers the decimal number sent as digit characters 0-9.
- Decoded digits are accumulated as packed BCD and presented as a parallel word with a one-cycle valid strobe when the word gap ends the number.
- Used as a loop-back checker for the LED Morse readout and as a debug input for the processor top level.

Parameters:
- UNIT_CYCLES, 4800000, clock cycles per Morse time unit (100 ms at 48 MHz); minimum 4.
- NUM_DIGITS, 8, BCD digits held in value_o.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- serial_i  in  1  asynchronous Morse line; 1 = mark, 0 = space
- value_o  out  4*NUM_DIGITS  packed BCD result; most recent digit in [3:0]
- digits_o  out  $clog2(NUM_DIGITS+1)  digit count of last word, saturating at NUM_DIGITS
- valid_o  out  1  one-cycle pulse: value_o/digits_o updated
- overflow_o  out  1  with valid_o: more than NUM_DIGITS digits received, oldest digits dropped
- error_o  out  1  one-cycle pulse: malformed character or over-long mark
- busy_o  out  1  high from first mark until word end or error recovery

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, counters and shift registers cleared. Reset mid-word discards the partial word; no valid_o or error_o is issued for it.
- Input path: serial_i passes through a 2-flop synchroniser. All timing is measured on the synchronised signal, so there is a fixed 2-cycle input latency.
- Duration counter: counts cycles since the last synchronised edge. It saturates at 8*UNIT_CYCLES. Its width is $clog2(8*UNIT_CYCLES+1).
- Mark classification, made on the falling edge:
  - length < 2*UNIT_CYCLES: dot (0).
  - 2*UNIT_CYCLES up to and including 5*UNIT_CYCLES: dash (1).
  - Reaching 5*UNIT_CYCLES+1 while still high: error immediately.
- Space classification, made while low or on the rising edge:
  - < 2*UNIT_CYCLES: intra-character gap, no action.
  - Reaching 2*UNIT_CYCLES: character end, so the current symbol group is committed.
  - Reaching 5*UNIT_CYCLES: word end.
- Symbol group: 5-bit shift register (first symbol in MSB) plus a 3-bit symbol count. A 6th symbol in one character is an error.
- Digit decode at character end:
  - Count must equal 5.
  - Pattern must be k dots then 5-k dashes, giving digit k for k = 1..5 (k = 5 encodes 5).
  - Or k dashes then 5-k dots, giving digit (k+5) mod 10 for k = 1..5 (five dashes = 0).
  - Anything else is an error.
- Valid digit: the accumulator shifts left 4 bits and the digit is inserted in [3:0]. The digit counter increments. If the counter is already NUM_DIGITS, the MSD is lost and a sticky overflow flag is set.
- States:
  - IDLE: line low, busy_o = 0. Rising edge goes to MARK.
  - MARK: on falling edge, append symbol and go to SPACE. Over-long mark goes to ERROR.
  - SPACE: rising edge before character end goes to MARK. At character end, commit the digit and stay in SPACE; an invalid digit goes to ERROR. A rising edge after character end starts the next character's MARK. At word end, go to IDLE and output the word.
  - ERROR: error_o pulses on entry. Accumulator, count and flags clear. Wait until the line has been low for 5*UNIT_CYCLES, then go to IDLE. Marks during ERROR restart the wait.
- Word output, on the IDLE-entry cycle only:
  - If the digit count is >= 1: value_o <= accumulator, digits_o <= count, overflow_o <= sticky flag, valid_o = 1 for one cycle. The accumulator, count and flag then clear.
  - A word with 0 digits (not possible without error) produces no valid_o.
- value_o/digits_o/overflow_o hold between words. They are not cleared by errors.
- Simultaneous events:
  - Character-end threshold and a rising edge in the same cycle: the commit takes priority, then MARK is entered.
  - error_o and valid_o are never asserted together.
- Pure combinational decode plus FSM; no handshake back-pressure; valid_o is not held.

Test Plan (UNIT_CYCLES = 4, NUM_DIGITS = 8):
- Send "1" (.----) then 7-unit space -> valid_o pulses once; value_o = 32'h00000001, digits_o = 1, overflow_o = 0, error_o never asserted.
- Send "2","0","5" with 3-unit character gaps, then 7-unit gap -> value_o = 32'h00000205, digits_o = 3.
- Send nine digits "123456789" -> value_o = 32'h23456789, digits_o = 8, overflow_o = 1 with valid_o.
- Send malformed character ".-.-." -> error_o pulse at character end, no valid_o. Then after 5 units of low, send "7" -> valid_o with value_o = 32'h00000007.
- Hold mark for 6 units -> error_o pulse at cycle 5*4+1 of the mark (plus synchroniser latency), busy_o stays high until 5 low units elapse.
- Assert rst_i mid-character after 2 symbols -> all outputs 0 immediately. After release, a complete "9" (----.) decodes cleanly to value_o = 32'h00000009.
